// File: rtl/c8_result_fifo.sv
// Result capture FIFO for the c8 datapath: first-word-fall-through queue with
// valid/ready on both sides, a sticky overflow flag and a saturating flagged-word count.
module c8_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 17
) (
    input  logic                     pclk,
    input  logic                     prst_n,
    input  logic                     pin_valid,
    input  logic [W-1:0]             pin_data,
    output logic                     pin_ready,
    output logic                     pout_valid,
    output logic [W-1:0]             pout_data,
    input  logic                     pout_ready,
    output logic [$clog2(DEPTH):0]   pcount,
    output logic                     povf,
    output logic [7:0]               pflag_cnt,
    input  logic                     pclr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CountFull = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    flag_cnt_q, flag_cnt_d;
    logic          push, pop, flagged_push;

    // Ready/valid decode only from registered occupancy, so no path from pout_ready.
    assign pin_ready  = (count_q < CountFull);
    assign pout_valid = (count_q != '0);
    assign pout_data  = pout_valid ? mem[rptr_q] : '0;
    assign pcount     = count_q;
    assign povf       = ovf_q;
    assign pflag_cnt  = flag_cnt_q;

    assign push         = pin_valid & pin_ready;
    assign pop          = pout_valid & pout_ready;
    assign flagged_push = push & pin_data[W-1];

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        flag_cnt_d = flag_cnt_q;

        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear still leaves the flag set.
        if (pin_valid && !pin_ready) begin
            ovf_d = 1'b1;
        end else if (pclr) begin
            ovf_d = 1'b0;
        end

        if (pclr) begin
            flag_cnt_d = flagged_push ? 8'd1 : 8'd0;
        end else if (flagged_push && (flag_cnt_q != 8'hFF)) begin
            flag_cnt_d = flag_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            flag_cnt_q <= 8'd0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            flag_cnt_q <= flag_cnt_d;
        end
    end

    // Storage needs no reset: it is only read while the occupancy says it holds a word.
    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wptr_q] <= pin_data;
        end
    end

endmodule

// File: tb/tb_c8_result_fifo.sv
// Scoreboard bench for c8_result_fifo: a queue-based reference model predicts
// acceptance, occupancy, overflow and flag count; a monitor checks every popped word.
module tb_c8_result_fifo;

    localparam int DEPTH = 4;
    localparam int W     = 17;

    logic          pclk = 1'b0;
    logic          prst_n;
    logic          pin_valid;
    logic [W-1:0]  pin_data;
    logic          pin_ready;
    logic          pout_valid;
    logic [W-1:0]  pout_data;
    logic          pout_ready;
    logic [2:0]    pcount;
    logic          povf;
    logic [7:0]    pflag_cnt;
    logic          pclr;

    c8_result_fifo #(.DEPTH(DEPTH), .W(W)) dut (
        .pclk       (pclk),
        .prst_n     (prst_n),
        .pin_valid  (pin_valid),
        .pin_data   (pin_data),
        .pin_ready  (pin_ready),
        .pout_valid (pout_valid),
        .pout_data  (pout_data),
        .pout_ready (pout_ready),
        .pcount     (pcount),
        .povf       (povf),
        .pflag_cnt  (pflag_cnt),
        .pclr       (pclr)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: words currently held, sticky overflow, flag count.
    logic [W-1:0] model_q [$];
    logic [W-1:0] exp_q [$];
    int           m_ovf  = 0;
    int           m_flag = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT hands over a word, it must be the oldest expected one.
    always @(negedge pclk) begin
        if (prst_n === 1'b1 && pout_valid === 1'b1 && pout_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 1, 0);
            end else begin
                chk("pout_data", int'(pout_data), int'(exp_q.pop_front()));
            end
        end
    end

    // One clock cycle: drive, check state at negedge, then advance the model at the edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic c);
        bit do_push, do_pop;
        pin_valid  = v;
        pin_data   = d;
        pout_ready = r;
        pclr       = c;
        @(negedge pclk);
        chk("pin_ready", int'(pin_ready), int'(model_q.size() < DEPTH));
        chk("pout_valid", int'(pout_valid), int'(model_q.size() > 0));
        chk("pcount", int'(pcount), model_q.size());
        chk("povf", int'(povf), m_ovf);
        chk("pflag_cnt", int'(pflag_cnt), m_flag);
        if (model_q.size() == 0) chk("empty_data_zero", int'(pout_data), 0);
        do_push = v && (model_q.size() < DEPTH);
        do_pop  = r && (model_q.size() > 0);
        if (do_push) exp_q.push_back(d);
        @(posedge pclk);
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(d);
        if (v && !do_push) m_ovf = 1;
        else if (c) m_ovf = 0;
        if (c) m_flag = (do_push && d[16]) ? 1 : 0;
        else if (do_push && d[16] && m_flag < 255) m_flag++;
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pout_valid"}, int'(pout_valid), 0);
        chk({tag, "_pout_data"}, int'(pout_data), 0);
        chk({tag, "_pcount"}, int'(pcount), 0);
        chk({tag, "_povf"}, int'(povf), 0);
        chk({tag, "_pflag_cnt"}, int'(pflag_cnt), 0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("drained_exp_q", exp_q.size(), 0);
    endtask

    initial begin
        prst_n     = 1'b0;
        pin_valid  = 1'b0;
        pin_data   = '0;
        pout_ready = 1'b0;
        pclr       = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        prst_n = 1'b1;
        @(posedge pclk);
        #1;

        // 1: single flagged word, consumer ready
        step(1'b1, 17'h1_A5_3C, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // 2: fill, overflow drop, drain in order
        for (int i = 0; i < 4; i++) step(1'b1, W'(32'h11 + i), 1'b0, 1'b0);
        step(1'b1, 17'h00015, 1'b0, 1'b0);
        drain();

        // 3: steady stream at occupancy 2
        step(1'b1, 17'h00100, 1'b0, 1'b0);
        step(1'b1, 17'h00101, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, W'(32'h200 + i), 1'b1, 1'b0);
        drain();

        // 4: flag count saturation, then clear coincident with a flagged push
        for (int i = 0; i < 260; i++) step(1'b1, {1'b1, 16'($urandom)}, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, {1'b1, 16'($urandom)}, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        drain();

        // Randomized traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 15) == 0));
        end
        drain();
        step(1'b0, '0, 1'b0, 1'b1);

        // 5: full, pop and push attempted together
        for (int i = 0; i < 4; i++) step(1'b1, W'(32'h300 + i), 1'b0, 1'b0);
        step(1'b1, 17'h1_FF_FF, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("full_pop_pcount", int'(pcount), 3);

        // 6: asynchronous reset mid-stream, away from the clock edge
        #2;
        prst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_q.delete();
        exp_q.delete();
        m_ovf  = 0;
        m_flag = 0;
        @(posedge pclk);
        @(negedge pclk);
        prst_n = 1'b1;
        @(posedge pclk);
        #1;
        chk("post_reset_ready", int'(pin_ready), 1);
        step(1'b1, 17'h0_5A_C3, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
